// File: rtl/trace_capture_ctrl_if.sv
// Handshake and memory-port bundle between the trace deserializer, the capture
// controller and the trace memory write port.
interface trace_capture_ctrl_if #(
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned ADDR_BITS = $clog2(DEPTH);

    logic                 ARM_I;
    logic                 DISARM_I;
    logic                 STREAM_I;
    logic [ADDR_BITS-1:0] TRG_DELAY_I;
    logic                 TRIGGER_I;
    logic [ADDR_BITS-1:0] READ_PTR_I;
    logic                 STORE_I;
    logic                 STORE_PERM_O;
    logic                 MEM_WE_O;
    logic [ADDR_BITS-1:0] MEM_WADDR_O;
    logic [ADDR_BITS-1:0] TRG_ADDR_O;
    logic                 BUSY_O;
    logic                 TRIGGERED_O;
    logic                 DONE_O;
    logic                 WRAPPED_O;

    modport master (
        output ARM_I, DISARM_I, STREAM_I, TRG_DELAY_I, TRIGGER_I, READ_PTR_I, STORE_I,
        input  STORE_PERM_O, MEM_WE_O, MEM_WADDR_O, TRG_ADDR_O, BUSY_O, TRIGGERED_O,
               DONE_O, WRAPPED_O
    );

    modport slave (
        input  ARM_I, DISARM_I, STREAM_I, TRG_DELAY_I, TRIGGER_I, READ_PTR_I, STORE_I,
        output STORE_PERM_O, MEM_WE_O, MEM_WADDR_O, TRG_ADDR_O, BUSY_O, TRIGGERED_O,
               DONE_O, WRAPPED_O
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: store permission, ring/stream write addressing and
// pre/post-trigger windowing for the trace memory.
module trace_capture_ctrl #(
    parameter int unsigned DEPTH = 64
) (
    input logic                  CLK_I,
    input logic                  RST_I,
    trace_capture_ctrl_if.slave  bus
);
    localparam int unsigned ADDR_BITS = $clog2(DEPTH);
    localparam logic [ADDR_BITS-1:0] AddrMax   = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS:0]   FullLevel = (ADDR_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StPre, StPost, StDone} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] wptr_q, wptr_d;
    logic [ADDR_BITS-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_BITS-1:0] trg_addr_q, trg_addr_d;
    logic [ADDR_BITS-1:0] delay_q, delay_d;
    logic                 triggered_q, triggered_d;
    logic                 wrapped_q, wrapped_d;
    logic                 stream_q, stream_d;

    logic                 active, room, remaining, we;
    logic [ADDR_BITS-1:0] occ;
    logic [ADDR_BITS:0]   occ_next;
    logic [ADDR_BITS-1:0] store_ext;

    assign store_ext = ADDR_BITS'(bus.STORE_I);
    assign active    = (state_q == StPre) || (state_q == StPost);
    assign occ       = wptr_q - bus.READ_PTR_I;
    // The in-flight store already claims a slot; one slot always stays free.
    assign occ_next  = {1'b0, occ} + (ADDR_BITS + 1)'(bus.STORE_I);
    assign room      = !stream_q || (occ_next < FullLevel);
    assign remaining = (state_q == StPre) || (post_cnt_q > store_ext);
    assign we        = bus.STORE_I && active && !bus.ARM_I;

    assign bus.STORE_PERM_O = active && room && remaining;
    assign bus.MEM_WE_O     = we;
    assign bus.MEM_WADDR_O  = wptr_q;
    assign bus.TRG_ADDR_O   = trg_addr_q;
    assign bus.BUSY_O       = active;
    assign bus.TRIGGERED_O  = triggered_q;
    assign bus.DONE_O       = (state_q == StDone);
    assign bus.WRAPPED_O    = wrapped_q;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        post_cnt_d  = post_cnt_q;
        trg_addr_d  = trg_addr_q;
        delay_d     = delay_q;
        triggered_d = triggered_q;
        wrapped_d   = wrapped_q;
        stream_d    = stream_q;

        if (bus.ARM_I) begin
            state_d     = StPre;
            wptr_d      = '0;
            triggered_d = 1'b0;
            wrapped_d   = 1'b0;
            stream_d    = bus.STREAM_I;
            delay_d     = bus.TRG_DELAY_I;
        end else begin
            if (we) begin
                wptr_d = wptr_q + ADDR_BITS'(1);
                if (!stream_q && (wptr_q == AddrMax)) wrapped_d = 1'b1;
            end
            unique case (state_q)
                StPre: begin
                    if (bus.DISARM_I) begin
                        state_d = StIdle;
                    end else if (bus.TRIGGER_I) begin
                        // A store in the trigger cycle still belongs to the pre-trigger window.
                        trg_addr_d  = wptr_q + store_ext;
                        triggered_d = 1'b1;
                        post_cnt_d  = delay_q;
                        state_d     = (delay_q != '0) ? StPost : StDone;
                    end
                end
                StPost: begin
                    if (bus.DISARM_I) begin
                        state_d = StIdle;
                    end else if (we) begin
                        post_cnt_d = post_cnt_q - ADDR_BITS'(1);
                        if (post_cnt_q == ADDR_BITS'(1)) state_d = StDone;
                    end
                end
                StDone: begin
                    if (bus.DISARM_I) state_d = StIdle;
                end
                StIdle: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            post_cnt_q  <= '0;
            trg_addr_q  <= '0;
            delay_q     <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
            stream_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            post_cnt_q  <= post_cnt_d;
            trg_addr_q  <= trg_addr_d;
            delay_q     <= delay_d;
            triggered_q <= triggered_d;
            wrapped_q   <= wrapped_d;
            stream_q    <= stream_d;
        end
    end
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Randomized bench for trace_capture_ctrl: a deserializer model drives the store
// handshake, a reference model fills scoreboard queues, a monitor compares.
module tb_trace_capture_ctrl;
    localparam int Depth = 8;
    localparam int AW    = $clog2(Depth);
    localparam int PhIdle = 0, PhPre = 1, PhPost = 2, PhDone = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_capture_ctrl_if #(.DEPTH(Depth)) bus ();
    trace_capture_ctrl #(.DEPTH(Depth)) dut (.CLK_I(clk), .RST_I(rst), .bus(bus.slave));

    typedef struct {
        int perm; int we; int waddr; int trg; int busy; int trig; int done; int wrap;
    } status_t;
    typedef struct { int cyc; int addr; } wr_t;

    status_t sq[$];
    wr_t     wq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic perm_s = 1'b0;

    // Reference model: capture phase, line pointer, lines still owed after trigger.
    int m_ph, m_wptr, m_left, m_trg, m_trig, m_wrap, m_stream, m_delay;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = PhIdle; m_wptr = 0; m_left = 0; m_trg = 0;
        m_trig = 0; m_wrap = 0; m_stream = 0; m_delay = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_perm"}, int'(bus.STORE_PERM_O), 0);
        chk({tag, "_we"}, int'(bus.MEM_WE_O), 0);
        chk({tag, "_waddr"}, int'(bus.MEM_WADDR_O), 0);
        chk({tag, "_trg"}, int'(bus.TRG_ADDR_O), 0);
        chk({tag, "_busy"}, int'(bus.BUSY_O), 0);
        chk({tag, "_trig"}, int'(bus.TRIGGERED_O), 0);
        chk({tag, "_done"}, int'(bus.DONE_O), 0);
        chk({tag, "_wrap"}, int'(bus.WRAPPED_O), 0);
    endtask

    // Expected outputs for this cycle, then advance the model by one clock.
    task automatic model_step(input int arm, input int dis, input int trg, input int rp,
                              input int st, input int stream_in, input int delay_in);
        status_t s;
        int active, occ, room, rem, we, w0;
        active = (m_ph == PhPre || m_ph == PhPost);
        occ    = (m_wptr - rp + Depth) % Depth;
        room   = !m_stream || (occ + st < Depth - 1);
        rem    = (m_ph == PhPre) || (m_left - st > 0);
        we     = st && active && !arm;
        s.perm = active && room && rem;
        s.we = we; s.waddr = m_wptr; s.trg = m_trg; s.busy = active;
        s.trig = m_trig; s.done = (m_ph == PhDone); s.wrap = m_wrap;
        sq.push_back(s);
        if (we) wq.push_back('{cyc: cyc, addr: m_wptr});

        if (arm) begin
            m_ph = PhPre; m_wptr = 0; m_trig = 0; m_wrap = 0;
            m_stream = stream_in; m_delay = delay_in;
        end else begin
            w0 = m_wptr;
            if (we) begin
                if (!m_stream && m_wptr == Depth - 1) m_wrap = 1;
                m_wptr = (m_wptr + 1) % Depth;
            end
            if (dis && m_ph != PhIdle) begin
                m_ph = PhIdle;
            end else if (m_ph == PhPre && trg) begin
                m_trg = (w0 + st) % Depth; m_trig = 1; m_left = m_delay;
                m_ph = (m_delay != 0) ? PhPost : PhDone;
            end else if (m_ph == PhPost && we && m_left > 0) begin
                m_left--;
                if (m_left == 0) m_ph = PhDone;
            end
        end
    endtask

    always @(negedge clk) begin
        status_t e;
        wr_t w;
        perm_s = bus.STORE_PERM_O;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("perm", int'(bus.STORE_PERM_O), e.perm);
            chk("we", int'(bus.MEM_WE_O), e.we);
            chk("waddr", int'(bus.MEM_WADDR_O), e.waddr);
            chk("trg_addr", int'(bus.TRG_ADDR_O), e.trg);
            chk("busy", int'(bus.BUSY_O), e.busy);
            chk("triggered", int'(bus.TRIGGERED_O), e.trig);
            chk("done", int'(bus.DONE_O), e.done);
            chk("wrapped", int'(bus.WRAPPED_O), e.wrap);
        end
        if (bus.MEM_WE_O) begin
            if (wq.size() == 0) begin
                chk("write_expected", 1, 0);
            end else begin
                w = wq.pop_front();
                chk("write_cycle", cyc, w.cyc);
                chk("write_addr", int'(bus.MEM_WADDR_O), w.addr);
            end
        end
    end

    initial begin
        int arm, dis, trg, rp, st, stream_in, delay_in, did_rst;
        bus.ARM_I = 0; bus.DISARM_I = 0; bus.STREAM_I = 0; bus.TRG_DELAY_I = '0;
        bus.TRIGGER_I = 0; bus.READ_PTR_I = '0; bus.STORE_I = 0;
        rp = 0; did_rst = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!did_rst && m_ph == PhPost && cyc > 300) begin
                did_rst = 1;
                bus.ARM_I = 0; bus.DISARM_I = 0; bus.TRIGGER_I = 0; bus.STORE_I = 0;
                rst = 1'b1;
                #1;
                check_all_zero("async_reset");
                model_reset();
                model_step(0, 0, 0, rp, 0, 0, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                cyc++;
                model_step(0, 0, 0, rp, 0, 0, 0);
                continue;
            end
            arm = (m_ph == PhIdle || m_ph == PhDone) ? ($urandom_range(0, 3) == 0)
                                                      : ($urandom_range(0, 99) == 0);
            dis = !arm && m_ph != PhIdle && ($urandom_range(0, 79) == 0);
            trg = (m_ph == PhPre) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 7) == 0);
            stream_in = int'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: delay_in = 0;
                1: delay_in = 1;
                2: delay_in = 3;
                3: delay_in = Depth - 1;
                default: delay_in = int'($urandom_range(0, Depth - 1));
            endcase
            st = perm_s && ($urandom_range(0, 3) != 0);
            if (arm) rp = 0;
            else if ($urandom_range(0, 5) == 0 && rp != m_wptr) rp = (rp + 1) % Depth;

            bus.ARM_I = arm[0]; bus.DISARM_I = dis[0]; bus.TRIGGER_I = trg[0];
            bus.STREAM_I = stream_in[0]; bus.TRG_DELAY_I = AW'(delay_in);
            bus.READ_PTR_I = AW'(rp); bus.STORE_I = st[0];
            model_step(arm, dis, trg, rp, st, stream_in, delay_in);
        end
        @(negedge clk);
        #1;
        chk("writes_outstanding", wq.size(), 0);
        chk("async_reset_reached", did_rst, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
